// File: rtl/fpu_pre_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pre_pkg
// Description : Shared definitions for the FP multiply/divide pre-normaliser.
//               Holds the fpu_op encodings, the default field widths and the
//               per-operand class record produced by the unpack stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pre_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int FRAC_W_DEF = 23;

  // Only the divide encoding is decoded; every other code selects multiply.
  localparam logic [2:0] FPU_OP_MUL = 3'b010;
  localparam logic [2:0] FPU_OP_DIV = 3'b011;

  // Operand class. Exactly one of zero/inf/nan/dn is set for a special or
  // subnormal operand; all clear means a normal number.
  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic dn;
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fpu_lzc
// Description : Combinational leading-zero counter.
//   in_vec [WIDTH-1:0]  : vector to scan, MSB first
//   count  [CNT_W-1:0]  : number of zeros above the first set bit
//                         (WIDTH when in_vec is all zero)
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_lzc #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [CNT_W-1:0] count
);

  logic found;

  always_comb begin
    count = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_vec[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pre_norm_fmuldiv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : pre_norm_fmuldiv_pipe
// Description : Two-stage pre-normaliser for FP multiply/divide.
//   S1 unpacks both operands, classifies them and left-justifies subnormal
//   mantissas. S2 forms the biased result exponent and the special-case
//   flags. Valid/ready on both sides; S2 holds while the consumer stalls.
// Ports:
//   clk, reset                : clock, async active-high reset
//   in_valid/in_ready         : input handshake
//   fpu_op, opa, opb          : operation (3'b011 divide) and packed operands
//   out_valid/out_ready       : output handshake
//   fracta, fractb            : normalised mantissas (zero for zero operands)
//   exp_out                   : signed biased result exponent, EXP_W+2 bits
//   sign, sign_exe            : signa^signb, signa&signb
//   exp_ovf..div_zero         : result class flags
// Revision    : 1.0 - initial release
// ============================================================================
module pre_norm_fmuldiv_pipe
  import fpu_pre_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                fpu_op,
  input  logic [EXP_W+FRAC_W:0]     opa,
  input  logic [EXP_W+FRAC_W:0]     opb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FRAC_W:0]           fracta,
  output logic [FRAC_W:0]           fractb,
  output logic [EXP_W+1:0]          exp_out,
  output logic                      sign,
  output logic                      sign_exe,
  output logic                      exp_ovf,
  output logic                      exp_unf,
  output logic                      res_inf,
  output logic                      res_nan,
  output logic                      res_zero,
  output logic                      div_zero
);

  localparam int OP_W   = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 1;
  localparam int XW     = EXP_W + 2;
  localparam int LZ_W   = $clog2(MANT_W + 1);

  localparam logic signed [XW-1:0] BIAS    = XW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE     = XW'(1);

  // --------------------------------------------------------------------------
  // S1 combinational: unpack / classify / normalise each operand
  // --------------------------------------------------------------------------
  logic [1:0][OP_W-1:0] op_pair;
  assign op_pair = {opb, opa};

  for (genvar i = 0; i < 2; i++) begin : g_unpack
    logic [EXP_W-1:0]        e_fld;
    logic [FRAC_W-1:0]       f_fld;
    logic [LZ_W-1:0]         lz;
    op_class_t               cls;
    logic [MANT_W-1:0]       mant;
    logic signed [XW-1:0]    eff;

    assign e_fld = op_pair[i][OP_W-2:FRAC_W];
    assign f_fld = op_pair[i][FRAC_W-1:0];

    // Only the subnormal path consumes the count, so the hidden bit is
    // always scanned as 0 here.
    fpu_lzc #(.WIDTH(MANT_W), .CNT_W(LZ_W)) u_lzc (
      .in_vec ({1'b0, f_fld}),
      .count  (lz)
    );

    always_comb begin
      cls.zero = (e_fld == '0) && (f_fld == '0);
      cls.dn   = (e_fld == '0) && (f_fld != '0);
      cls.inf  = (&e_fld) && (f_fld == '0);
      cls.nan  = (&e_fld) && (f_fld != '0);
      mant     = {1'b1, f_fld};
      eff      = $signed({2'b00, e_fld});
      if (cls.zero) begin
        mant = '0;
      end else if (cls.dn) begin
        // Shift the first set bit up to the hidden-bit position; each
        // shift step costs one unit of exponent below the minimum of 1.
        mant = {1'b0, f_fld} << lz;
        eff  = ONE - $signed(XW'(lz));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv;

  assign s1_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s1_adv;
  assign out_valid = s2_valid_q;

  // --------------------------------------------------------------------------
  // S1 registers
  // --------------------------------------------------------------------------
  logic                 s1_div_q,    s1_div_d;
  logic [1:0]           s1_sgn_q,    s1_sgn_d;     // bit0 = a, bit1 = b
  logic [1:0]           s1_zero_q,   s1_zero_d;
  logic [1:0]           s1_inf_q,    s1_inf_d;
  logic [1:0]           s1_nan_q,    s1_nan_d;
  logic [MANT_W-1:0]    s1_ma_q,     s1_ma_d;
  logic [MANT_W-1:0]    s1_mb_q,     s1_mb_d;
  logic signed [XW-1:0] s1_ea_q,     s1_ea_d;
  logic signed [XW-1:0] s1_eb_q,     s1_eb_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_div_d   = s1_div_q;
    s1_sgn_d   = s1_sgn_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    s1_nan_d   = s1_nan_q;
    s1_ma_d    = s1_ma_q;
    s1_mb_d    = s1_mb_q;
    s1_ea_d    = s1_ea_q;
    s1_eb_d    = s1_eb_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_div_d  = (fpu_op == FPU_OP_DIV);
        s1_sgn_d  = {opb[OP_W-1], opa[OP_W-1]};
        s1_zero_d = {g_unpack[1].cls.zero, g_unpack[0].cls.zero};
        s1_inf_d  = {g_unpack[1].cls.inf,  g_unpack[0].cls.inf};
        s1_nan_d  = {g_unpack[1].cls.nan,  g_unpack[0].cls.nan};
        s1_ma_d   = g_unpack[0].mant;
        s1_mb_d   = g_unpack[1].mant;
        s1_ea_d   = g_unpack[0].eff;
        s1_eb_d   = g_unpack[1].eff;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S2 combinational: exponent and special cases
  // --------------------------------------------------------------------------
  logic signed [XW-1:0] exp_calc;
  logic nan_c, inf_c, zero_c, dz_c, special_c;

  always_comb begin
    nan_c  = 1'b0;
    inf_c  = 1'b0;
    zero_c = 1'b0;
    dz_c   = 1'b0;
    if (s1_div_q) begin
      exp_calc = s1_ea_q - s1_eb_q + BIAS;
      nan_c    = (|s1_nan_q) || (&s1_zero_q) || (&s1_inf_q);
      if (!nan_c) begin
        // With NaN excluded, a non-inf non-zero dividend is finite nonzero.
        dz_c   = !s1_inf_q[0] && !s1_zero_q[0] && s1_zero_q[1];
        inf_c  = s1_inf_q[0] || dz_c;
        zero_c = s1_zero_q[0] || s1_inf_q[1];
      end
    end else begin
      exp_calc = s1_ea_q + s1_eb_q - BIAS;
      nan_c    = (|s1_nan_q) || (s1_zero_q[0] && s1_inf_q[1]) ||
                 (s1_inf_q[0] && s1_zero_q[1]);
      if (!nan_c) begin
        inf_c  = |s1_inf_q;
        zero_c = |s1_zero_q;
      end
    end
    special_c = nan_c || inf_c || zero_c;
  end

  // --------------------------------------------------------------------------
  // S2 / output registers
  // --------------------------------------------------------------------------
  logic [MANT_W-1:0] fracta_q,   fracta_d;
  logic [MANT_W-1:0] fractb_q,   fractb_d;
  logic [XW-1:0]     exp_out_q,  exp_out_d;
  logic              sign_q,     sign_d;
  logic              sign_exe_q, sign_exe_d;
  logic              exp_ovf_q,  exp_ovf_d;
  logic              exp_unf_q,  exp_unf_d;
  logic              res_inf_q,  res_inf_d;
  logic              res_nan_q,  res_nan_d;
  logic              res_zero_q, res_zero_d;
  logic              div_zero_q, div_zero_d;

  always_comb begin
    s2_valid_d = s2_valid_q;
    fracta_d   = fracta_q;
    fractb_d   = fractb_q;
    exp_out_d  = exp_out_q;
    sign_d     = sign_q;
    sign_exe_d = sign_exe_q;
    exp_ovf_d  = exp_ovf_q;
    exp_unf_d  = exp_unf_q;
    res_inf_d  = res_inf_q;
    res_nan_d  = res_nan_q;
    res_zero_d = res_zero_q;
    div_zero_d = div_zero_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      // Leave the output registers untouched on bubbles.
      if (s1_valid_q) begin
        fracta_d   = s1_ma_q;
        fractb_d   = s1_mb_q;
        exp_out_d  = exp_calc;
        sign_d     = s1_sgn_q[0] ^ s1_sgn_q[1];
        sign_exe_d = s1_sgn_q[0] & s1_sgn_q[1];
        exp_ovf_d  = !special_c && (exp_calc >= EXP_MAX);
        exp_unf_d  = !special_c && (exp_calc[XW-1] || (exp_calc == '0));
        res_inf_d  = inf_c;
        res_nan_d  = nan_c;
        res_zero_d = zero_c;
        div_zero_d = dz_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_div_q   <= 1'b0;
      s1_sgn_q   <= '0;
      s1_zero_q  <= '0;
      s1_inf_q   <= '0;
      s1_nan_q   <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
      s1_ea_q    <= '0;
      s1_eb_q    <= '0;
      s2_valid_q <= 1'b0;
      fracta_q   <= '0;
      fractb_q   <= '0;
      exp_out_q  <= '0;
      sign_q     <= 1'b0;
      sign_exe_q <= 1'b0;
      exp_ovf_q  <= 1'b0;
      exp_unf_q  <= 1'b0;
      res_inf_q  <= 1'b0;
      res_nan_q  <= 1'b0;
      res_zero_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_div_q   <= s1_div_d;
      s1_sgn_q   <= s1_sgn_d;
      s1_zero_q  <= s1_zero_d;
      s1_inf_q   <= s1_inf_d;
      s1_nan_q   <= s1_nan_d;
      s1_ma_q    <= s1_ma_d;
      s1_mb_q    <= s1_mb_d;
      s1_ea_q    <= s1_ea_d;
      s1_eb_q    <= s1_eb_d;
      s2_valid_q <= s2_valid_d;
      fracta_q   <= fracta_d;
      fractb_q   <= fractb_d;
      exp_out_q  <= exp_out_d;
      sign_q     <= sign_d;
      sign_exe_q <= sign_exe_d;
      exp_ovf_q  <= exp_ovf_d;
      exp_unf_q  <= exp_unf_d;
      res_inf_q  <= res_inf_d;
      res_nan_q  <= res_nan_d;
      res_zero_q <= res_zero_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign fracta   = fracta_q;
  assign fractb   = fractb_q;
  assign exp_out  = exp_out_q;
  assign sign     = sign_q;
  assign sign_exe = sign_exe_q;
  assign exp_ovf  = exp_ovf_q;
  assign exp_unf  = exp_unf_q;
  assign res_inf  = res_inf_q;
  assign res_nan  = res_nan_q;
  assign res_zero = res_zero_q;
  assign div_zero = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pre_norm_fmuldiv_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_pre_norm_fmuldiv_pipe
// Description : Self-checking bench for pre_norm_fmuldiv_pipe (single
//               precision defaults) against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pre_norm_fmuldiv_pipe;

  typedef struct packed {
    logic [23:0] fa;
    logic [23:0] fb;
    logic [9:0]  e;
    logic s, se, ovf, unf, inf, nan, zero, dz;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fpu_op;
  logic [31:0] opa, opb;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] fracta, fractb;
  logic [9:0]  exp_out;
  logic        sign, sign_exe, exp_ovf, exp_unf, res_inf, res_nan, res_zero, div_zero;

  int total = 0;
  int bad   = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  pre_norm_fmuldiv_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fpu_op(fpu_op), .opa(opa), .opb(opb), .out_valid(out_valid),
    .out_ready(out_ready), .fracta(fracta), .fractb(fractb), .exp_out(exp_out),
    .sign(sign), .sign_exe(sign_exe), .exp_ovf(exp_ovf), .exp_unf(exp_unf),
    .res_inf(res_inf), .res_nan(res_nan), .res_zero(res_zero), .div_zero(div_zero)
  );

  // ---------------- reference model ----------------
  function automatic void unpack(input logic [31:0] x, output logic [23:0] m,
                                 output int e, output bit z, output bit inf,
                                 output bit nan);
    int fe;
    logic [22:0] f;
    fe = int'(x[30:23]);
    f  = x[22:0];
    z = 0; inf = 0; nan = 0;
    e = fe;
    m = {1'b1, f};
    if (fe == 255) begin
      inf = (f == 0);
      nan = (f != 0);
    end else if (fe == 0 && f == 0) begin
      z = 1; m = '0; e = 0;
    end else if (fe == 0) begin
      m = {1'b0, f};
      e = 1;
      while (!m[23]) begin
        m = m << 1;
        e = e - 1;
      end
    end
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
    res_t r;
    int ea, eb, ex;
    bit za, ia, na, zb, ib, nb, div, special;
    logic [23:0] ma, mb;
    unpack(a, ma, ea, za, ia, na);
    unpack(b, mb, eb, zb, ib, nb);
    div = (op == 3'b011);
    ex  = div ? (ea - eb + 127) : (ea + eb - 127);
    r = '0;
    r.fa = ma;
    r.fb = mb;
    r.e  = 10'(ex);
    r.s  = a[31] ^ b[31];
    r.se = a[31] & b[31];
    r.nan = na || nb || (div ? ((za && zb) || (ia && ib)) : ((za && ib) || (ia && zb)));
    if (!r.nan) begin
      if (div) begin
        r.dz   = !ia && !za && zb;
        r.inf  = ia || r.dz;
        r.zero = za || ib;
      end else begin
        r.inf  = ia || ib;
        r.zero = za || zb;
      end
    end
    special = r.nan || r.inf || r.zero;
    r.ovf = !special && (ex >= 255);
    r.unf = !special && (ex <= 0);
    return r;
  endfunction

  function automatic res_t dut_res();
    res_t r;
    r.fa = fracta; r.fb = fractb; r.e = exp_out;
    r.s = sign; r.se = sign_exe; r.ovf = exp_ovf; r.unf = exp_unf;
    r.inf = res_inf; r.nan = res_nan; r.zero = res_zero; r.dz = div_zero;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [22:0] f;
    logic        s;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 6))
      0:       return {s, 8'h00, 23'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, f | 23'h1};
      3:       return {s, 8'h00, (f >> $urandom_range(0, 22)) | 23'h1};
      4:       return {s, 8'($urandom_range(120, 135)), f};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  function automatic logic [2:0] rand_fop();
    return ($urandom_range(0, 1) == 1) ? 3'b011 : 3'($urandom_range(0, 7));
  endfunction

  // ---------------- directed vectors ----------------
  logic [31:0] va  [6] = '{32'h40000000, 32'h7F000000, 32'h00000001,
                           32'h3F800000, 32'h00000000, 32'h40000000};
  logic [31:0] vb  [6] = '{32'h40400000, 32'h7F000000, 32'h3F800000,
                           32'h00000000, 32'h7F800000, 32'h40400000};
  logic [2:0]  vop [6] = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b010, 3'b011};
  int          ve  [6] = '{129, 381, -22, 254, 128, 127};

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    fpu_op = 3'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (dut_res() !== res_t'(0)) begin bad++; $display("FAIL reset_outputs: got %h want 0", dut_res()); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    res_t m;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opa = va[i]; opb = vb[i]; fpu_op = vop[i]; out_ready = 1'b1;
      m = model(va[i], vb[i], vop[i]);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early: got out_valid %b want 0", i, out_valid); end
      @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency: got out_valid %b want 1", i, out_valid); end
      total++; if (dut_res() !== m) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, dut_res(), m); end
      total++; if (int'($signed(exp_out)) != ve[i]) begin bad++; $display("FAIL dir%0d_exp: got %0d want %0d", i, $signed(exp_out), ve[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ia [4], ib [4];
    logic [2:0]  iop [4];
    int   sent = 0, got = 0;
    bit   stalled = 0;
    res_t snap;
    for (int i = 0; i < 4; i++) begin ia[i] = rand_op(); ib[i] = rand_op(); iop[i] = rand_fop(); end
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      if (sent < 4) begin opa = ia[sent]; opb = ib[sent]; fpu_op = iop[sent]; end
      #1;
      if (stalled) begin
        total++; if (dut_res() !== snap) begin bad++; $display("FAIL bp_hold: got %h want %h", dut_res(), snap); end
      end
      if (cyc == 2) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0 after 2 accepts", in_ready); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_spurious: got %h want none", dut_res()); end
        else begin
          if (dut_res() !== exp_q[0]) begin bad++; $display("FAIL bp_result%0d: got %h want %h", got, dut_res(), exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      snap    = dut_res();
      if (in_valid && in_ready) begin exp_q.push_back(model(opa, opb, fpu_op)); sent++; end
    end
    in_valid = 1'b0;
    total++; if (got != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", got); end
  endtask

  task automatic test_random();
    int   got = 0, sent = 0;
    bit   stalled = 0;
    res_t snap;
    exp_q.delete();
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(negedge clk);
      if (cyc < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        opa = rand_op(); opb = rand_op(); fpu_op = rand_fop();
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (stalled) begin
        total++; if (dut_res() !== snap) begin bad++; $display("FAIL rnd_hold: got %h want %h", dut_res(), snap); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_spurious: got %h want none", dut_res()); end
        else begin
          if (dut_res() !== exp_q[0]) begin bad++; $display("FAIL rnd_result%0d: got %h want %h", got, dut_res(), exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      snap    = dut_res();
      if (in_valid && in_ready) begin exp_q.push_back(model(opa, opb, fpu_op)); sent++; end
    end
    total++; if (exp_q.size() != 0 || got != sent) begin bad++; $display("FAIL rnd_drain: got %0d results want %0d", got, sent); end
  endtask

  task automatic test_reset_mid();
    res_t m;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; opa = rand_op(); opb = rand_op(); fpu_op = rand_fop();
    @(negedge clk);
    opa = rand_op(); opb = rand_op(); fpu_op = rand_fop();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL rm_full: got v=%b r=%b want v=1 r=0", out_valid, in_ready); end
    reset = 1'b1;
    #1;
    total++; if (dut_res() !== res_t'(0)) begin bad++; $display("FAIL rm_clear: got %h want 0", dut_res()); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    opa = 32'h40000000; opb = 32'h40400000; fpu_op = 3'b010;
    m = model(opa, opb, fpu_op);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_latency: got %b want 1", out_valid); end
    total++; if (dut_res() !== m) begin bad++; $display("FAIL rm_result: got %h want %h", dut_res(), m); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pre_norm_fmuldiv_pipe.md
PRE_NORM_FMULDIV_PIPE -- requirements
Module: pre_norm_fmuldiv_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width; operand width OP_W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the input handshake.
REQ-006 SHALL have port fpu_op  input  3  operation select: 3'b011 = divide, any other value = multiply.
REQ-007 SHALL have ports opa and opb  input  OP_W  packed IEEE-style operands {sign, exp, frac}.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, the output handshake.
REQ-009 SHALL have ports fracta and fractb  output  FRAC_W+1  normalized mantissas, MSB = 1 unless the operand is zero.
REQ-010 SHALL have port exp_out  output  EXP_W+2  signed two's-complement biased result exponent.
REQ-011 SHALL have ports sign and sign_exe  output  1  signa^signb and signa&signb.
REQ-012 SHALL have ports exp_ovf, exp_unf, res_inf, res_nan, res_zero, div_zero  output  1 each  result class flags.

Function
REQ-013 SHALL be a 2-stage pipeline (S1 unpack/classify/normalize, S2 exponent/special-case) with latency 2 cycles when out_ready=1.
REQ-014 SHALL accept input when in_valid&in_ready; hold S2 when out_valid&!out_ready; in_ready = !s1_valid | S1-advance, S1-advance = !s2_valid | out_ready.
REQ-015 SHALL deliver full throughput (one result per cycle) under continuous out_ready=1, with no loss, duplication or reordering under any stall pattern.
REQ-016 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, for a subnormal operand (exp=0, frac!=0), left-shift {0,frac} by its leading-zero count s and use effective exponent 1-s; normal operands use {1,frac} and exp.
REQ-018 SHALL compute exp_out = ea+eb-B (multiply) or ea-eb+B (divide), B = 2^(EXP_W-1)-1, in EXP_W+2 signed bits without wrap.
REQ-019 SHALL set exp_ovf when exp_out >= 2^EXP_W-1, exp_unf when exp_out <= 0; both forced 0 when any of res_inf/res_nan/res_zero is set.
REQ-020 SHALL set res_nan for any NaN input, 0*inf, inf*0, 0/0 or inf/inf.
REQ-021 SHALL set res_inf (when not NaN) for an inf operand in multiply, inf dividend, or finite nonzero / zero; div_zero only for that last case.
REQ-022 SHALL set res_zero (when not NaN) for a zero operand in multiply, zero dividend, or finite / inf.
REQ-023 SHALL drive zero fractions (all bits 0) for zero operands; NaN/inf operands pass {1,frac} unchanged.

Reset
REQ-024 SHALL, on reset assertion, clear both stage valids immediately, so out_valid=0 and in_ready=1 from the following edge, discarding in-flight data.
REQ-025 SHALL reset every output register (fracta, fractb, exp_out, sign, sign_exe, all flags) to 0.

Structure
REQ-026 SHALL take the fpu_op encodings, default EXP_W/FRAC_W and the operand-class struct (zero, inf, nan, dn) from shared package fpu_pre_pkg.
REQ-027 SHALL instantiate sub-module fpu_lzc (parametrised leading-zero counter, width FRAC_W+1) once per operand in S1.

Verification
REQ-028 SHALL cover 2.0*3.0: opa=0x40000000, opb=0x40400000, op=010 -> 2 cycles later exp_out=129, fracta=0x800000, fractb=0xC00000, sign=0, all flags 0.
REQ-029 SHALL cover overflow/subnormal: 0x7F000000*0x7F000000 -> exp_out=381, exp_ovf=1; 0x00000001*0x3F800000 -> fracta=0x800000, exp_out=-22, exp_unf=1.
REQ-030 SHALL cover specials: 0x3F800000/0x00000000 op=011 -> res_inf=1, div_zero=1; 0x00000000*0x7F800000 -> res_nan=1, res_inf=0.
REQ-031 SHALL cover backpressure: 4 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready falls after 2 accepted, all 4 results emerge in order, outputs stable while stalled.
REQ-032 SHALL cover reset mid-operation: reset pulse with both stages valid -> out_valid=0, in_ready=1 after release, next input returns correct result at latency 2.
